// File: rtl/data_cache_if.sv
// CPU request/response and Memory strobe/address signals of the data cache.
// The cache side uses the slave modport; the CPU/memory environment uses master.
interface data_cache_if #(
    parameter int WORD_SIZE = 16
);
    logic                 cpu_read;
    logic                 cpu_write;
    logic [WORD_SIZE-1:0] cpu_address;
    logic [WORD_SIZE-1:0] cpu_wdata;
    logic [WORD_SIZE-1:0] cpu_rdata;
    logic                 cpu_done;
    logic                 d_readM;
    logic                 d_writeM;
    logic [WORD_SIZE-1:0] d_address;
    logic [15:0]          num_hits;
    logic [15:0]          num_access;

    modport master (
        output cpu_read, cpu_write, cpu_address, cpu_wdata,
        input  cpu_rdata, cpu_done, d_readM, d_writeM, d_address, num_hits, num_access
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_address, cpu_wdata,
        output cpu_rdata, cpu_done, d_readM, d_writeM, d_address, num_hits, num_access
    );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Read misses fill a whole line from Memory; writes go to Memory one word at a time.
module data_cache #(
    parameter int WORD_SIZE        = 16,
    parameter int MEMORY_BANDWIDTH = 64,
    parameter int NUM_LINES        = 4,
    parameter int MEM_LATENCY      = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    data_cache_if.slave                 bus,
    inout  wire [MEMORY_BANDWIDTH-1:0]  d_data
);
    localparam int LINE_WORDS = MEMORY_BANDWIDTH / WORD_SIZE;
    localparam int OFF_W      = $clog2(LINE_WORDS);
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int TAG_W      = WORD_SIZE - OFF_W - IDX_W;
    localparam int CNT_W      = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic [WORD_SIZE-1:0]   rdata_q, rdata_d;
    logic [15:0]            hits_q, hits_d;
    logic [15:0]            acc_q, acc_d;
    logic                   wr_hit_q, wr_hit_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;

    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    logic [WORD_SIZE-1:0]   data_q [NUM_LINES][LINE_WORDS];

    logic [OFF_W-1:0]       offset;
    logic [IDX_W-1:0]       index;
    logic [TAG_W-1:0]       tag;
    logic                   hit;
    logic                   fill_en;
    logic                   wupd_en;
    logic [WORD_SIZE-1:0]   fill_word [LINE_WORDS];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign offset = bus.cpu_address[OFF_W-1:0];
    assign index  = bus.cpu_address[OFF_W +: IDX_W];
    assign tag    = bus.cpu_address[WORD_SIZE-1 -: TAG_W];
    assign hit    = valid_q[index] && (tag_q[index] == tag);

    // Word at the block base address sits in the most significant slice of the bus.
    always_comb begin
        for (int k = 0; k < LINE_WORDS; k++) begin
            fill_word[k] = d_data[MEMORY_BANDWIDTH-1-k*WORD_SIZE -: WORD_SIZE];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        rdata_d  = rdata_q;
        hits_d   = hits_q;
        acc_d    = acc_q;
        wr_hit_d = wr_hit_q;
        valid_d  = valid_q;
        fill_en  = 1'b0;
        wupd_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!done_q) begin
                    if (bus.cpu_write) begin
                        state_d  = WRITE;
                        cnt_d    = CNT_W'(MEM_LATENCY - 1);
                        wr_hit_d = hit;
                        wupd_en  = hit;
                    end else if (bus.cpu_read) begin
                        if (hit) begin
                            rdata_d = data_q[index][offset];
                            done_d  = 1'b1;
                            hits_d  = sat_inc(hits_q);
                            acc_d   = sat_inc(acc_q);
                        end else begin
                            state_d = FILL;
                            cnt_d   = CNT_W'(MEM_LATENCY);
                        end
                    end
                end
            end
            FILL: begin
                if (cnt_q == '0) begin
                    fill_en        = 1'b1;
                    valid_d[index] = 1'b1;
                    rdata_d        = fill_word[offset];
                    done_d         = 1'b1;
                    acc_d          = sat_inc(acc_q);
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WRITE: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    acc_d   = sat_inc(acc_q);
                    if (wr_hit_q) begin
                        hits_d = sat_inc(hits_q);
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
            hits_q   <= '0;
            acc_q    <= '0;
            wr_hit_q <= 1'b0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            hits_q   <= hits_d;
            acc_q    <= acc_d;
            wr_hit_q <= wr_hit_d;
            valid_q  <= valid_d;
        end
    end

    // Tag and data arrays are not cleared by reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[index] <= tag;
            for (int k = 0; k < LINE_WORDS; k++) begin
                data_q[index][k] <= fill_word[k];
            end
        end else if (wupd_en) begin
            data_q[index][offset] <= bus.cpu_wdata;
        end
    end

    assign bus.cpu_rdata  = rdata_q;
    assign bus.cpu_done   = done_q;
    assign bus.num_hits   = hits_q;
    assign bus.num_access = acc_q;
    assign bus.d_readM    = (state_q == FILL);
    assign bus.d_writeM   = (state_q == WRITE);
    assign bus.d_address  = (state_q == FILL)  ? {bus.cpu_address[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}} :
                            (state_q == WRITE) ? bus.cpu_address : '0;
    assign d_data = (state_q == WRITE) ? {{(MEMORY_BANDWIDTH-WORD_SIZE){1'b0}}, bus.cpu_wdata}
                                       : {MEMORY_BANDWIDTH{1'bz}};
endmodule
